bcd_to_binary_seq: RTL and testbench

Sequential converter from a 3-digit BCD value (CENT, DEZ, UNI) back to an 8-bit binary number. It is the inverse of the combinational binary-to-BCD path. It uses reverse double-dabble: shift right one bit per cycle, then subtract 3 from any BCD nibble that is 8 or more. It sits between the keypad/display digit registers and the arithmetic datapath, and is driven by a start/done handshake.

---
 rtl/bcd_pkg.sv | 23 ++
 rtl/sub3.sv | 17 +
 rtl/bcd_to_binary_seq.sv | 157 +++++++++++++++
 tb/tb_bcd_to_binary_seq.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the sequential BCD-to-binary converter.
//   estado_t  : FSM state encoding (OCIOSO idle, CONVERTE shifting, FIM done)
//   N_BITS    : width of the binary result
//   N_ITER    : number of shift iterations per conversion
//   CORRECAO  : amount removed from a BCD nibble after a right shift
//   LIMIAR    : nibble value at or above which the correction applies
// -----------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        CONVERTE = 2'd1,
        FIM      = 2'd2
    } estado_t;

    localparam int N_BITS   = 8;
    localparam int N_ITER   = 8;
    localparam int CORRECAO = 3;
    localparam int LIMIAR   = 8;

endpackage

// File: rtl/sub3.sv
// -----------------------------------------------------------------------------
// sub3
// Combinational BCD nibble corrector for reverse double-dabble; the inverse of
// the add3 cell used by the binary-to-BCD path.
//   nib_i [3:0] : nibble after the right shift
//   nib_o [3:0] : nib_i - 3 when nib_i >= 8, otherwise nib_i
// -----------------------------------------------------------------------------
module sub3
    import bcd_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [3:0] nib_o
);

    assign nib_o = (nib_i >= 4'(LIMIAR)) ? nib_i - 4'(CORRECAO) : nib_i;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// -----------------------------------------------------------------------------
// bcd_to_binary_seq
// Sequential 3-digit BCD to 8-bit binary converter (reverse double-dabble,
// one shift per cycle, start/done handshake).
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   start    : one-cycle request, accepted only when idle
//   CENT     : hundreds digit (0-2)
//   DEZ      : tens digit (0-9)
//   UNI      : units digit (0-9)
//   A        : registered binary result, held until the next result
//   ocupado  : high while a conversion is in progress
//   pronto   : one-cycle pulse when A is updated
//   erro     : illegal digit or overflow, valid with pronto
// Configuration macro: BCD_TO_BIN_ERRO_EN enables digit validation, the
// overflow check and the erro output; when undefined erro is tied to 0 and
// every start runs the full conversion.
// -----------------------------------------------------------------------------
module bcd_to_binary_seq
    import bcd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        CENT,
    input  logic [3:0]        DEZ,
    input  logic [3:0]        UNI,
    output logic [N_BITS-1:0] A,
    output logic              ocupado,
    output logic              pronto,
    output logic              erro
);

    estado_t           state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [9:0]        bcd_q, bcd_d;
    logic [N_BITS-1:0] bin_q, bin_d;
    logic [N_BITS-1:0] a_q, a_d;
    logic              ocupado_q, ocupado_d;
    logic              pronto_q, pronto_d;

    // One right shift of the concatenated {bcd, bin} register.
    logic [9:0]        bcd_sh;
    logic [N_BITS-1:0] bin_sh;
    logic [3:0]        dez_corr, uni_corr;

    assign bcd_sh = {1'b0, bcd_q[9:1]};
    assign bin_sh = {bcd_q[0], bin_q[N_BITS-1:1]};

    // The hundreds field never reaches 8 after a shift, so it needs no corrector.
    sub3 u_sub3_dez (.nib_i(bcd_sh[7:4]), .nib_o(dez_corr));
    sub3 u_sub3_uni (.nib_i(bcd_sh[3:0]), .nib_o(uni_corr));

`ifdef BCD_TO_BIN_ERRO_EN
    logic ilegal_q, ilegal_d;
    logic erro_q, erro_d;
    logic digito_ilegal;

    assign digito_ilegal = (CENT == 2'd3) || (DEZ > 4'd9) || (UNI > 4'd9);
`endif

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        a_d       = a_q;
        ocupado_d = ocupado_q;
        pronto_d  = 1'b0;
`ifdef BCD_TO_BIN_ERRO_EN
        ilegal_d  = ilegal_q;
        erro_d    = erro_q;
`endif
        case (state_q)
            OCIOSO: begin
                if (start) begin
                    bcd_d     = {CENT, DEZ, UNI};
                    bin_d     = '0;
                    cnt_d     = '0;
                    ocupado_d = 1'b1;
                    state_d   = CONVERTE;
`ifdef BCD_TO_BIN_ERRO_EN
                    erro_d    = 1'b0;
                    ilegal_d  = digito_ilegal;
                    if (digito_ilegal) begin
                        // Skip shifting; clearing bcd leaves only the flag to
                        // drive erro and keeps the result at zero.
                        bcd_d   = '0;
                        state_d = FIM;
                    end
`endif
                end
            end
            CONVERTE: begin
                bcd_d = {bcd_sh[9:8], dez_corr, uni_corr};
                bin_d = bin_sh;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == 3'(N_ITER - 1)) begin
                    state_d = FIM;
                end
            end
            FIM: begin
                a_d       = bin_q;
                pronto_d  = 1'b1;
                ocupado_d = 1'b0;
`ifdef BCD_TO_BIN_ERRO_EN
                // Anything left in bcd after all shifts means the value exceeded 255.
                erro_d    = ilegal_q || (bcd_q != 10'd0);
`endif
                state_d   = OCIOSO;
            end
            default: state_d = OCIOSO;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= OCIOSO;
            cnt_q     <= '0;
            bcd_q     <= '0;
            bin_q     <= '0;
            a_q       <= '0;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
`ifdef BCD_TO_BIN_ERRO_EN
            ilegal_q  <= 1'b0;
            erro_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            a_q       <= a_d;
            ocupado_q <= ocupado_d;
            pronto_q  <= pronto_d;
`ifdef BCD_TO_BIN_ERRO_EN
            ilegal_q  <= ilegal_d;
            erro_q    <= erro_d;
`endif
        end
    end

    assign A       = a_q;
    assign ocupado = ocupado_q;
    assign pronto  = pronto_q;
`ifdef BCD_TO_BIN_ERRO_EN
    assign erro    = erro_q;
`else
    assign erro    = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// -----------------------------------------------------------------------------
// tb_bcd_to_binary_seq
// Directed self-checking bench for bcd_to_binary_seq. Expected values are
// hand-computed; expectations for erro and illegal-digit latency follow
// BCD_TO_BIN_ERRO_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_bcd_to_binary_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] CENT;
    logic [3:0] DEZ;
    logic [3:0] UNI;
    logic [7:0] A;
    logic       ocupado;
    logic       pronto;
    logic       erro;

    int errors = 0;
    int checks = 0;

`ifdef BCD_TO_BIN_ERRO_EN
    localparam bit ERRO_EN = 1'b1;
`else
    localparam bit ERRO_EN = 1'b0;
`endif

    bcd_to_binary_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .CENT    (CENT),
        .DEZ     (DEZ),
        .UNI     (UNI),
        .A       (A),
        .ocupado (ocupado),
        .pronto  (pronto),
        .erro    (erro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start with the given digits, then wait (bounded) for pronto.
    task automatic run_conv(input string tag, input logic [1:0] c, input logic [3:0] d,
                            input logic [3:0] u, input int exp_lat, input bit chk_a,
                            input logic [7:0] exp_a, input logic exp_erro);
        int  n;
        bit  busy_ok;
        CENT  = c;
        DEZ   = d;
        UNI   = u;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " ocupado_after_accept"}, 32'(ocupado), 32'd1);
        n       = 0;
        busy_ok = 1'b1;
        while (n < 20) begin
            tick();
            n++;
            if (pronto) break;
            if (!ocupado) busy_ok = 1'b0;
        end
        check({tag, " latency"}, n, exp_lat);
        check({tag, " ocupado_held"}, 32'(busy_ok), 32'd1);
        if (chk_a) check({tag, " A"}, 32'(A), 32'(exp_a));
        check({tag, " erro"}, 32'(erro), 32'(exp_erro));
        check({tag, " ocupado_done"}, 32'(ocupado), 32'd0);
        tick();
        check({tag, " pronto_single"}, 32'(pronto), 32'd0);
    endtask

    initial begin
        int n_pronto;
        rst   = 1'b1;
        start = 1'b0;
        CENT  = '0;
        DEZ   = '0;
        UNI   = '0;
        tick();
        tick();
        check("reset A", 32'(A), 32'd0);
        check("reset ocupado", 32'(ocupado), 32'd0);
        check("reset pronto", 32'(pronto), 32'd0);
        check("reset erro", 32'(erro), 32'd0);
        rst = 1'b0;
        tick();

        // Legal conversions: max, zero, mid-range.
        run_conv("max255", 2'd2, 4'd5, 4'd5, 9, 1'b1, 8'd255, 1'b0);
        run_conv("zero",   2'd0, 4'd0, 4'd0, 9, 1'b1, 8'd0,   1'b0);
        run_conv("v128",   2'd1, 4'd2, 4'd8, 9, 1'b1, 8'd128, 1'b0);
        run_conv("v42a",   2'd0, 4'd4, 4'd2, 9, 1'b1, 8'd42,  1'b0);

        // Overflow: 299 mod 256 = 43; erro only when checking is enabled.
        run_conv("ovf299", 2'd2, 4'd9, 4'd9, 9, 1'b1, 8'd43, ERRO_EN);

        // Illegal digits: immediate reject when enabled, full run otherwise.
        if (ERRO_EN) begin
            run_conv("ileg_dez10", 2'd0, 4'd10, 4'd0, 1, 1'b1, 8'd0, 1'b1);
            run_conv("ileg_cent3", 2'd3, 4'd0,  4'd0, 1, 1'b1, 8'd0, 1'b1);
        end else begin
            run_conv("ileg_dez10", 2'd0, 4'd10, 4'd0, 9, 1'b0, 8'd0, 1'b0);
            run_conv("ileg_cent3", 2'd3, 4'd0,  4'd0, 9, 1'b0, 8'd0, 1'b0);
        end
        // A legal result after an error clears erro on the next accept.
        run_conv("v1_after_err", 2'd0, 4'd0, 4'd1, 9, 1'b1, 8'd1, 1'b0);

        // Busy start with changed digits: ignored, original digits kept.
        CENT  = 2'd1;
        DEZ   = 4'd0;
        UNI   = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        CENT  = 2'd0;
        DEZ   = 4'd0;
        UNI   = 4'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_pronto = 0;
        for (int i = 0; i < 5; i++) begin
            if (pronto) n_pronto++;
            tick();
        end
        check("busy pronto_at_E9", 32'(pronto), 32'd1);
        check("busy A", 32'(A), 32'd100);
        check("busy early_pronto", n_pronto, 0);
        n_pronto = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (pronto) n_pronto++;
        end
        check("busy no_second_pronto", n_pronto, 0);
        check("busy A_held", 32'(A), 32'd100);
        run_conv("fresh7", 2'd0, 4'd0, 4'd7, 9, 1'b1, 8'd7, 1'b0);

        // Reset mid-conversion aborts with no pronto.
        CENT  = 2'd0;
        DEZ   = 4'd5;
        UNI   = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("rstmid A", 32'(A), 32'd0);
        check("rstmid ocupado", 32'(ocupado), 32'd0);
        check("rstmid pronto", 32'(pronto), 32'd0);
        check("rstmid erro", 32'(erro), 32'd0);
        rst = 1'b0;
        n_pronto = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (pronto) n_pronto++;
        end
        check("rstmid no_pronto", n_pronto, 0);
        run_conv("v42b", 2'd0, 4'd4, 4'd2, 9, 1'b1, 8'd42, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
